hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_ctrl_cmp.sv | 23 ++
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and opcode decode for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_MWAIT  = 2'd2
  } state_e;

  localparam int OPC_RTYPE = 0;
  localparam int OPC_BEQ   = 4;
  localparam int OPC_BNE   = 5;
  localparam int OPC_LW    = 35;
  localparam int OPC_SW    = 43;

  // Rt is read as an operand only by R-type, branches and stores.
  function automatic logic rt_is_src(input logic [31:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_BEQ) ||
           (opc == OPC_BNE)   || (opc == OPC_SW);
  endfunction

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// Combinational load-use detector: register match against the load target, $zero never hazards.
module hazard_cmp import hazard_pkg::*; #(
  parameter int REG_W = 5,
  parameter int OPC_W = 6
) (
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic [OPC_W-1:0] ifid_opc,
  output logic             luse
);

  logic rt_src;
  logic rs_hit;
  logic rt_hit;

  assign rt_src = rt_is_src(32'(ifid_opc));
  assign rs_hit = (idex_rt == ifid_rs);
  assign rt_hit = rt_src && (idex_rt == ifid_rt);
  assign luse   = idex_mem_read && (idex_rt != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Stateful hazard controller: multi-cycle load-use bubbles, branch/jump flushes,
// and a whole-pipeline freeze on data-memory wait with a sticky watchdog.
module hazard_ctrl import hazard_pkg::*; #(
  parameter int REG_W       = 5,
  parameter int OPC_W       = 6,
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic [OPC_W-1:0] ifid_opc,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic             mem_timeout
);

  localparam int SCW = $clog2(LOAD_LAT + 1);
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);

  state_e         state_q, state_d, eff_state;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           ret_lstall_q, ret_lstall_d;
  logic           mem_timeout_q, mem_timeout_d;
  logic           luse;

  hazard_cmp #(.REG_W(REG_W), .OPC_W(OPC_W)) u_cmp (
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .ifid_opc      (ifid_opc),
    .luse          (luse)
  );

  // Leaving MWAIT behaves exactly like the state it returns to, in the same cycle.
  assign eff_state = (state_q == ST_MWAIT) ? (ret_lstall_q ? ST_LSTALL : ST_RUN) : state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      stall_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      ret_lstall_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      ret_lstall_q  <= ret_lstall_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    stall_cnt_d   = stall_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    ret_lstall_d  = ret_lstall_q;
    mem_timeout_d = mem_timeout_q;
    if (!dmem_ready) begin
      state_d = ST_MWAIT;
      if (state_q == ST_MWAIT) begin
        if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
      end else begin
        wait_cnt_d   = WCW'(1);
        ret_lstall_d = (state_q == ST_LSTALL);
      end
      if (wait_cnt_d == WAIT_MAX) mem_timeout_d = 1'b1;
    end else begin
      wait_cnt_d = '0;
      state_d    = ST_RUN;
      if (branch_taken) begin
        stall_cnt_d = '0;
      end else if (eff_state == ST_LSTALL) begin
        stall_cnt_d = stall_cnt_q - 1'b1;
        if (stall_cnt_q != SCW'(1)) state_d = ST_LSTALL;
      end else if (luse && (LOAD_LAT > 1)) begin
        state_d     = ST_LSTALL;
        stall_cnt_d = SCW'(LOAD_LAT - 1);
      end
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    if (rst) begin
      if (!dmem_ready) begin
        pipe_hold  = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end else if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if ((eff_state == ST_LSTALL) || luse) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end else if (jump) begin
        ifid_flush = 1'b1;
      end
    end
  end

  assign mem_timeout = mem_timeout_q && rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Drives three hazard_ctrl configurations with shared directed vectors and checks every cycle
// against a bubble-count / zero-run model, plus hand-computed literal expectations.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r = 1'b0, mr = 1'b0, br = 1'b0, j = 1'b0, dr = 1'b1;
  logic [4:0] xrt = '0, rs = '0, rt = '0;
  logic [5:0] opc = '0;
  logic [2:0] pcw, ifw, flu, bub, hld, mto;

  // k=0: LOAD_LAT=1/MEM_TIMEOUT=255, k=1: 3/8, k=2: 2/8
  hazard_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(255)) u_k0 (
    .clk(clk), .rst(r), .idex_mem_read(mr), .idex_rt(xrt), .ifid_rs(rs), .ifid_rt(rt),
    .ifid_opc(opc), .branch_taken(br), .jump(j), .dmem_ready(dr),
    .pc_write(pcw[0]), .ifid_write(ifw[0]), .ifid_flush(flu[0]), .idex_bubble(bub[0]),
    .pipe_hold(hld[0]), .mem_timeout(mto[0]));
  hazard_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(8)) u_k1 (
    .clk(clk), .rst(r), .idex_mem_read(mr), .idex_rt(xrt), .ifid_rs(rs), .ifid_rt(rt),
    .ifid_opc(opc), .branch_taken(br), .jump(j), .dmem_ready(dr),
    .pc_write(pcw[1]), .ifid_write(ifw[1]), .ifid_flush(flu[1]), .idex_bubble(bub[1]),
    .pipe_hold(hld[1]), .mem_timeout(mto[1]));
  hazard_ctrl #(.LOAD_LAT(2), .MEM_TIMEOUT(8)) u_k2 (
    .clk(clk), .rst(r), .idex_mem_read(mr), .idex_rt(xrt), .ifid_rs(rs), .ifid_rt(rt),
    .ifid_opc(opc), .branch_taken(br), .jump(j), .dmem_ready(dr),
    .pc_write(pcw[2]), .ifid_write(ifw[2]), .ifid_flush(flu[2]), .idex_bubble(bub[2]),
    .pipe_hold(hld[2]), .mem_timeout(mto[2]));

  function automatic int ll_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 2;
  endfunction
  function automatic int mt_of(input int k);
    return (k == 0) ? 255 : 8;
  endfunction

  bit         lit_en [3] = '{0, 0, 0};
  logic [5:0] lit_exp[3] = '{6'd0, 6'd0, 6'd0};
  string      lit_name[3];

  int n_cmp = 0, n_bad = 0;
  int pend[3] = '{0, 0, 0};
  int zrun[3] = '{0, 0, 0};
  bit tout[3] = '{0, 0, 0};

  // Output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_timeout}
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [5:0] act, e;
      bit lu, tn;
      act = {pcw[k], ifw[k], flu[k], bub[k], hld[k], mto[k]};
      lu  = mr && (xrt != 0) &&
            ((xrt == rs) || (((opc == 0) || (opc == 4) || (opc == 5) || (opc == 43)) && (xrt == rt)));
      tn  = tout[k];
      if (!r) begin
        e = 6'b110000; pend[k] = 0; zrun[k] = 0; tn = 1'b0;
      end else if (!dr) begin
        e = 6'b000010;
        if (zrun[k] < mt_of(k)) zrun[k]++;
        if (zrun[k] >= mt_of(k)) tn = 1'b1;
      end else begin
        zrun[k] = 0;
        if (br) begin e = 6'b111100; pend[k] = 0; end
        else if (pend[k] > 0) begin e = 6'b000100; pend[k]--; end
        else if (lu) begin e = 6'b000100; pend[k] = ll_of(k) - 1; end
        else if (j) e = 6'b111000;
        else e = 6'b110000;
      end
      e[0] = r && tout[k];
      tout[k] = tn;
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL model k%0d t=%0t got %b want %b", k, $time, act, e);
      end
      if (lit_en[k]) begin
        n_cmp++;
        if (act !== lit_exp[k]) begin
          n_bad++;
          $display("FAIL %s k%0d t=%0t got %b want %b", lit_name[k], k, $time, act, lit_exp[k]);
        end
      end
    end
  end

  task automatic drv(input bit r_i, input bit mr_i, input int xrt_i, input int rs_i, input int rt_i,
                     input int opc_i, input bit br_i, input bit j_i, input bit dr_i);
    @(posedge clk); #1;
    r = r_i; mr = mr_i; xrt = 5'(xrt_i); rs = 5'(rs_i); rt = 5'(rt_i); opc = 6'(opc_i);
    br = br_i; j = j_i; dr = dr_i;
    lit_en = '{0, 0, 0};
  endtask
  task automatic ex(input int k, input logic [5:0] e, input string nm);
    lit_en[k] = 1'b1; lit_exp[k] = e; lit_name[k] = nm;
  endtask
  task automatic idle(); drv(1, 0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic lu();   drv(1, 1, 5, 5, 0, 0, 0, 0, 1); endtask
  task automatic hold(); drv(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic rstc(); drv(0, 0, 0, 0, 0, 0, 0, 0, 1); endtask

  initial begin
    rstc(); rstc();
    for (int k = 0; k < 3; k++) ex(k, 6'b110000, "reset");
    idle(); ex(0, 6'b110000, "idle");
    lu();   ex(0, 6'b000100, "lu1_stall");
    idle(); ex(0, 6'b110000, "lu1_release");
    idle();
    drv(1, 1, 0, 0, 0, 0, 0, 0, 1);  ex(0, 6'b110000, "zero_reg"); ex(1, 6'b110000, "zero_reg");
    drv(1, 1, 7, 3, 7, 35, 0, 0, 1); ex(0, 6'b110000, "lw_rt_not_src");
    drv(1, 1, 7, 3, 7, 43, 0, 0, 1); ex(0, 6'b000100, "sw_rt_src");
    idle(); idle();
    lu();   ex(1, 6'b000100, "ll3_b1");
    idle(); ex(1, 6'b000100, "ll3_b2");
    idle(); ex(1, 6'b000100, "ll3_b3");
    idle(); ex(1, 6'b110000, "ll3_done");
    lu();   ex(1, 6'b000100, "ll3_retrig");
    drv(1, 0, 0, 0, 0, 0, 1, 0, 1); ex(1, 6'b111100, "ll3_abort");
    idle(); ex(1, 6'b110000, "ll3_run");
    drv(1, 1, 5, 5, 0, 0, 1, 0, 1);
    for (int k = 0; k < 3; k++) ex(k, 6'b111100, "br_luse");
    idle();
    for (int k = 0; k < 3; k++) ex(k, 6'b110000, "br_no_stall");
    drv(1, 0, 0, 0, 0, 0, 0, 1, 1); ex(0, 6'b111000, "jump");
    lu();   ex(2, 6'b000100, "ll2_b1");
    for (int i = 0; i < 4; i++) begin hold(); ex(2, 6'b000010, "ll2_hold"); end
    idle(); ex(2, 6'b000100, "ll2_resume");
    idle(); ex(2, 6'b110000, "ll2_done");
    idle();
    for (int i = 1; i <= 10; i++) begin
      hold();
      if (i == 8)  ex(1, 6'b000010, "to_before");
      if (i == 9)  ex(1, 6'b000011, "to_rise");
      if (i == 10) begin ex(1, 6'b000011, "to_hold"); ex(0, 6'b000010, "to_slow_cfg"); end
    end
    idle(); ex(1, 6'b110001, "to_sticky"); ex(0, 6'b110000, "to_slow_idle");
    rstc(); ex(1, 6'b110000, "to_rst");
    idle(); ex(1, 6'b110000, "to_clear");
    lu();   ex(1, 6'b000100, "mid_stall");
    rstc(); ex(1, 6'b110000, "mid_rst");
    idle(); ex(1, 6'b110000, "rst_mid_stall"); ex(2, 6'b110000, "rst_mid_stall");
    @(posedge clk); #1;
    lit_en = '{0, 0, 0};
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
